// File: rtl/alu_writeback_stage_pkg.sv
// Shared encodings and the writeback entry layout for the ALU writeback stage.
package alu_writeback_stage_pkg;

  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] EXC_ADD     = 32'd1;
  localparam logic [31:0] EXC_ADDI    = 32'd2;
  localparam logic [31:0] EXC_SUB     = 32'd3;

  typedef enum logic [2:0] {
    KIND_RTYPE = 3'd0,
    KIND_ADDI  = 3'd1,
    KIND_BNE   = 3'd2,
    KIND_BLT   = 3'd3,
    KIND_NOWB  = 3'd4
  } kind_e;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  // we | rd | data, 38 bits
  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/alu_writeback_stage_wb_skid_buffer.sv
// Generic 2-entry FIFO with occupancy count; head is always presented on data_o.
module wb_skid_buffer #(
  parameter int WIDTH = 38
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 2'd1;
    if (do_pop && !do_push) count_d = count_q - 2'd1;
  end

  // Storage and pointers; reset discards every buffered entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: overflow-exception rewrite, branch resolution and a
// 2-entry buffer towards register-file writeback.
module alu_writeback_stage
  import alu_writeback_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_isNotEqual,
  input  logic        in_isLessThan,
  input  logic        in_overflow,
  input  logic [2:0]  in_kind,
  input  logic [4:0]  in_aluop,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_we,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [15:0] exc_count
);

  wb_entry_t   entry_d, head;
  logic [1:0]  fifo_count;
  logic        fifo_valid;
  logic        accept, pop, exc_hit, taken;
  logic        is_rtype, is_addi;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;
  logic [15:0] exc_count_q;

  // The squash slot after a redirect blocks the upstream instruction that must be flushed.
  assign in_ready = (fifo_count != 2'd2) && !redirect_valid_q;
  assign accept   = in_valid && in_ready;
  assign pop      = fifo_valid && out_ready;

  assign is_rtype = (in_kind == KIND_RTYPE);
  assign is_addi  = (in_kind == KIND_ADDI);
  assign exc_hit  = in_overflow &&
                    ((is_rtype && (in_aluop == ALU_ADD || in_aluop == ALU_SUB)) || is_addi);
  assign taken    = ((in_kind == KIND_BNE) && in_isNotEqual) ||
                    ((in_kind == KIND_BLT) && in_isLessThan);

  // Build the writeback entry; non-writing kinds still occupy a slot to keep order.
  always_comb begin
    entry_d.we   = 1'b0;
    entry_d.rd   = in_rd;
    entry_d.data = in_result;
    if (exc_hit) begin
      entry_d.we = 1'b1;
      entry_d.rd = RSTATUS_REG;
      if (is_addi)                  entry_d.data = EXC_ADDI;
      else if (in_aluop == ALU_SUB) entry_d.data = EXC_SUB;
      else                          entry_d.data = EXC_ADD;
    end else if (is_rtype || is_addi) begin
      entry_d.we = (in_rd != 5'd0);
    end
  end

  wb_skid_buffer #(.WIDTH(ENTRY_W)) u_buf (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (accept),
    .data_i  (entry_d),
    .pop_i   (pop),
    .data_o  (head),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  // Redirect pulse for one cycle after a taken branch; the target is held afterwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      redirect_valid_q <= accept && taken;
      if (accept && taken) redirect_pc_q <= in_target;
    end
  end

  // Saturating overflow-exception counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exc_count_q <= 16'd0;
    end else if (accept && exc_hit && (exc_count_q != 16'hFFFF)) begin
      exc_count_q <= exc_count_q + 16'd1;
    end
  end

  assign out_valid      = fifo_valid;
  assign out_we         = fifo_valid && head.we;
  assign out_rd         = fifo_valid ? head.rd : 5'd0;
  assign out_data       = fifo_valid ? head.data : 32'd0;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign exc_count      = exc_count_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage with a queue-based reference model.
module tb_alu_writeback_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic        in_isNotEqual, in_isLessThan, in_overflow;
  logic [2:0]  in_kind;
  logic [4:0]  in_aluop, in_rd;
  logic [31:0] in_target;
  logic        out_valid, out_ready, out_we;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] exc_count;

  alu_writeback_stage dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_result      (in_result),
    .in_isNotEqual  (in_isNotEqual),
    .in_isLessThan  (in_isLessThan),
    .in_overflow    (in_overflow),
    .in_kind        (in_kind),
    .in_aluop       (in_aluop),
    .in_rd          (in_rd),
    .in_target      (in_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_we         (out_we),
    .out_rd         (out_rd),
    .out_data       (out_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_count      (exc_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } m_entry_t;

  m_entry_t    mq[$];
  logic        m_redir = 1'b0;
  logic [31:0] m_pc    = 32'd0;
  int          m_exc   = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          done     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_ready();
    return (mq.size() < 2) && !m_redir;
  endfunction

  // Reference model: applies the stage rules to a plain queue each rising edge.
  initial begin
    m_entry_t e, tmp;
    bit rdy, nr;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        m_redir = 1'b0;
        m_pc    = 32'd0;
        m_exc   = 0;
      end else begin
        rdy = m_ready();
        nr  = 1'b0;
        if (mq.size() > 0 && out_ready) tmp = mq.pop_front();
        if (in_valid && rdy) begin
          e.we = 1'b0; e.rd = 5'd0; e.data = 32'd0;
          if (in_overflow && (in_kind == 3'd1 ||
              (in_kind == 3'd0 && (in_aluop == 5'd0 || in_aluop == 5'd1)))) begin
            e.we = 1'b1;
            e.rd = 5'd30;
            e.data = (in_kind == 3'd1) ? 32'd2 : (in_aluop == 5'd0 ? 32'd1 : 32'd3);
            if (m_exc < 65535) m_exc++;
          end else if (in_kind <= 3'd1) begin
            e.we = (in_rd != 5'd0);
            e.rd = in_rd;
            e.data = in_result;
          end
          mq.push_back(e);
          if ((in_kind == 3'd2 && in_isNotEqual) || (in_kind == 3'd3 && in_isLessThan)) begin
            nr = 1'b1;
            m_pc = in_target;
          end
        end
        m_redir = nr;
      end
    end
  end

  // Every cycle: DUT outputs against the model state.
  initial begin
    forever begin
      @(negedge clock);
      if (!done) begin
        chk("out_valid", out_valid, mq.size() > 0);
        chk("in_ready", in_ready, m_ready());
        chk("redirect_valid", redirect_valid, m_redir);
        chk("redirect_pc", redirect_pc, m_pc);
        chk("exc_count", exc_count, m_exc);
        if (mq.size() > 0) begin
          chk("out_we", out_we, mq[0].we);
          if (mq[0].we) begin
            chk("out_rd", out_rd, mq[0].rd);
            chk("out_data", out_data, mq[0].data);
          end
        end else begin
          chk("out_we_empty", out_we, 1'b0);
        end
      end
    end
  end

  task automatic set_in(input logic [2:0] k, input logic [4:0] op, input logic [4:0] rd,
                        input logic [31:0] res, input logic ovf, input logic ne,
                        input logic lt, input logic [31:0] tgt);
    in_kind = k; in_aluop = op; in_rd = rd; in_result = res;
    in_overflow = ovf; in_isNotEqual = ne; in_isLessThan = lt; in_target = tgt;
    in_valid = 1'b1;
  endtask

  // Hold the presented instruction until the stage takes it, bounded.
  task automatic wait_accept();
    bit acc;
    int tries;
    tries = 0;
    do begin
      acc = m_ready();
      @(posedge clock); #2;
      tries++;
    end while (!acc && tries < 50);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] op, input logic [4:0] rd,
                      input logic [31:0] res, input logic ovf, input logic ne,
                      input logic lt, input logic [31:0] tgt);
    set_in(k, op, rd, res, ovf, ne, lt, tgt);
    wait_accept();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  initial begin
    reset_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    set_in(3'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_rd", out_rd, 5'd0);
    chk("rst_out_data", out_data, 32'd0);
    reset_n = 1'b1;
    idle(1);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // basic rtype writeback
    send(3'd0, 5'd0, 5'd7, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("basic_valid", out_valid, 1'b1);
    chk("basic_we", out_we, 1'b1);
    chk("basic_rd", out_rd, 5'd7);
    chk("basic_data", out_data, 32'd5);
    chk("basic_noredir", redirect_valid, 1'b0);

    // overflow exceptions: add, sub, addi
    send(3'd0, 5'd0, 5'd9, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("add_ovf_rd", out_rd, 5'd30);
    chk("add_ovf_data", out_data, 32'd1);
    chk("add_ovf_cnt", exc_count, 16'd1);
    send(3'd0, 5'd1, 5'd9, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("sub_ovf_data", out_data, 32'd3);
    chk("sub_ovf_cnt", exc_count, 16'd2);
    send(3'd1, 5'd0, 5'd9, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("addi_ovf_data", out_data, 32'd2);
    chk("addi_ovf_cnt", exc_count, 16'd3);

    // taken bne then untaken blt
    send(3'd2, 5'd1, 5'd3, 32'h1234, 1'b0, 1'b1, 1'b0, 32'h0000_0040);
    chk("bne_redir", redirect_valid, 1'b1);
    chk("bne_pc", redirect_pc, 32'h40);
    chk("bne_squash", in_ready, 1'b0);
    chk("bne_we", out_we, 1'b0);
    send(3'd3, 5'd1, 5'd3, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0000_0080);
    chk("blt_noredir", redirect_valid, 1'b0);
    chk("blt_pc_hold", redirect_pc, 32'h40);

    // rd=0 suppression and an ignored overflow flag
    send(3'd0, 5'd0, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rd0_we", out_we, 1'b0);
    send(3'd0, 5'd2, 5'd4, 32'h12, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("and_ovf_rd", out_rd, 5'd4);
    chk("and_ovf_cnt", exc_count, 16'd3);
    send(3'd3, 5'd1, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    send(3'd4, 5'd0, 5'd8, 32'h55, 1'b1, 1'b0, 1'b0, 32'd0);
    idle(1);

    // backpressure: two accepted, third held, then drain in order
    out_ready = 1'b0;
    send(3'd0, 5'd0, 5'd10, 32'hA, 1'b0, 1'b0, 1'b0, 32'd0);
    send(3'd0, 5'd0, 5'd11, 32'hB, 1'b0, 1'b0, 1'b0, 32'd0);
    set_in(3'd0, 5'd0, 5'd12, 32'hC, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(3);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_head_rd", out_rd, 5'd10);
    out_ready = 1'b1;
    #1;
    chk("full_ready_ignores_out_ready", in_ready, 1'b0);
    #1;
    wait_accept();
    chk("drain_head_rd", out_rd, 5'd12);
    send(3'd1, 5'd0, 5'd13, 32'hD, 1'b0, 1'b0, 1'b0, 32'd0);
    send(3'd1, 5'd0, 5'd14, 32'hE, 1'b0, 1'b0, 1'b0, 32'd0);
    out_ready = 1'b0;
    send(3'd0, 5'd0, 5'd15, 32'hF, 1'b0, 1'b0, 1'b0, 32'd0);
    out_ready = 1'b1;
    send(3'd0, 5'd0, 5'd16, 32'h10, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(3);

    // async reset with two entries buffered and a redirect pending
    out_ready = 1'b0;
    send(3'd0, 5'd0, 5'd5, 32'h77, 1'b0, 1'b0, 1'b0, 32'd0);
    send(3'd2, 5'd1, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0080);
    chk("pre_rst_redir", redirect_valid, 1'b1);
    chk("pre_rst_valid", out_valid, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_redir", redirect_valid, 1'b0);
    chk("async_rst_exc", exc_count, 16'd0);
    chk("async_rst_pc", redirect_pc, 32'd0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send(3'd0, 5'd0, 5'd6, 32'h66, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("post_rst_data", out_data, 32'h66);
    chk("post_rst_exc", exc_count, 16'd0);
    idle(3);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
